// File: rtl/mdio_arb.sv
// mdio_arb - round-robin arbiter between NREQ register-access clients and
// the single MDIO driver op interface.
//
// Each client has one request slot. A start pulse is latched only while the
// client is not busy. The arbiter issues one driver op at a time, picking
// the first pending client after the last one granted. It routes the
// completion back to that client. A down-counting watchdog aborts any op
// the driver never finishes.
//
// Ports
//   clk, rst                 clock and asynchronous active-high reset
//   req_exec   [NREQ]        per-client start pulse
//   req_rh_wl  [NREQ]        per-client direction (1 = read, 0 = write)
//   req_addr   [5*NREQ]      client i address at [5i+4:5i]
//   req_wr_data[16*NREQ]     client i write data at [16i+15:16i]
//   req_busy   [NREQ]        client request pending or in flight
//   req_done   [NREQ]        one-cycle completion pulse per client
//   req_err                  valid with req_done, 1 = aborted by watchdog
//   req_rd_data[16]          shared read data, valid with req_done
//   req_rd_ack               shared PHY ack, valid with req_done (0 = ack)
//   op_exec/op_rh_wl/op_addr/op_wr_data   op request to the driver
//   op_done/op_rd_data/op_rd_ack          completion from the driver
//
// state  | meaning
// IDLE   | no op in flight; grant the next pending client if any
// WAIT   | op issued; wait for op_done or watchdog terminal count
module mdio_arb #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_exec,
    input  logic [NREQ-1:0]      req_rh_wl,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [16*NREQ-1:0]   req_wr_data,
    output logic [NREQ-1:0]      req_busy,
    output logic [NREQ-1:0]      req_done,
    output logic                 req_err,
    output logic [15:0]          req_rd_data,
    output logic                 req_rd_ack,
    output logic                 op_exec,
    output logic                 op_rh_wl,
    output logic [4:0]           op_addr,
    output logic [15:0]          op_wr_data,
    input  logic                 op_done,
    input  logic [15:0]          op_rd_data,
    input  logic                 op_rd_ack
);

    localparam int              IW       = $clog2(NREQ);
    localparam logic [IW-1:0]   LAST_RST = IW'(NREQ - 1);
    localparam logic [15:0]     TO_LOAD  = 16'(TIMEOUT);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          state, state_nxt;

    logic            slot_rh_wl   [NREQ];
    logic [4:0]      slot_addr    [NREQ];
    logic [15:0]     slot_wr_data [NREQ];
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] take;
    logic [NREQ-1:0] clr;

    logic [IW-1:0]   last_grant, last_grant_nxt;
    logic [IW-1:0]   gnt, gnt_nxt;
    logic [15:0]     cnt, cnt_nxt;

    logic            grant_found;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   cand;

    logic            op_exec_nxt;
    logic            op_rh_wl_nxt;
    logic [4:0]      op_addr_nxt;
    logic [15:0]     op_wr_data_nxt;
    logic [NREQ-1:0] done_nxt;
    logic            err_nxt;
    logic [15:0]     rd_data_nxt;
    logic            rd_ack_nxt;

    // A pulse from a busy client is dropped. Because busy already reads 0
    // in the done cycle, a client can re-issue in that cycle without a
    // set/clear collision on its pending bit.
    assign take     = req_exec & ~pending;
    assign req_busy = pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                slot_rh_wl[i]   <= 1'b0;
                slot_addr[i]    <= 5'd0;
                slot_wr_data[i] <= 16'd0;
            end
            pending <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (take[i]) begin
                    slot_rh_wl[i]   <= req_rh_wl[i];
                    slot_addr[i]    <= req_addr[5*i +: 5];
                    slot_wr_data[i] <= req_wr_data[16*i +: 16];
                end
            end
            pending <= (pending & ~clr) | take;
        end
    end

    // Round-robin search starting one past the previous grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_grant) + k) % NREQ);
            if (!grant_found && pending[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= LAST_RST;
            gnt         <= '0;
            cnt         <= 16'd0;
            op_exec     <= 1'b0;
            op_rh_wl    <= 1'b0;
            op_addr     <= 5'd0;
            op_wr_data  <= 16'd0;
            req_done    <= '0;
            req_err     <= 1'b0;
            req_rd_data <= 16'd0;
            req_rd_ack  <= 1'b1;
        end else begin
            state       <= state_nxt;
            last_grant  <= last_grant_nxt;
            gnt         <= gnt_nxt;
            cnt         <= cnt_nxt;
            op_exec     <= op_exec_nxt;
            op_rh_wl    <= op_rh_wl_nxt;
            op_addr     <= op_addr_nxt;
            op_wr_data  <= op_wr_data_nxt;
            req_done    <= done_nxt;
            req_err     <= err_nxt;
            req_rd_data <= rd_data_nxt;
            req_rd_ack  <= rd_ack_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gnt_nxt        = gnt;
        cnt_nxt        = cnt;
        op_exec_nxt    = 1'b0;
        op_rh_wl_nxt   = op_rh_wl;
        op_addr_nxt    = op_addr;
        op_wr_data_nxt = op_wr_data;
        done_nxt       = '0;
        err_nxt        = req_err;
        rd_data_nxt    = req_rd_data;
        rd_ack_nxt     = req_rd_ack;
        clr            = '0;

        unique case (state)
            S_IDLE: begin
                if (grant_found) begin
                    op_exec_nxt    = 1'b1;
                    op_rh_wl_nxt   = slot_rh_wl[grant_idx];
                    op_addr_nxt    = slot_addr[grant_idx];
                    op_wr_data_nxt = slot_wr_data[grant_idx];
                    gnt_nxt        = grant_idx;
                    last_grant_nxt = grant_idx;
                    // Counter sits at TIMEOUT in the op_exec cycle and hits
                    // zero TIMEOUT cycles later, so the abort lands on
                    // req_done TIMEOUT+1 cycles after op_exec.
                    cnt_nxt        = TO_LOAD;
                    state_nxt      = S_WAIT;
                end
            end
            S_WAIT: begin
                // op_done wins over a simultaneous terminal count.
                if (op_done) begin
                    done_nxt[gnt] = 1'b1;
                    err_nxt       = 1'b0;
                    rd_data_nxt   = op_rd_data;
                    rd_ack_nxt    = op_rd_ack;
                    clr[gnt]      = 1'b1;
                    state_nxt     = S_IDLE;
                end else if (cnt == 16'd0) begin
                    done_nxt[gnt] = 1'b1;
                    err_nxt       = 1'b1;
                    rd_data_nxt   = 16'd0;
                    rd_ack_nxt    = 1'b1;
                    clr[gnt]      = 1'b1;
                    state_nxt     = S_IDLE;
                end else begin
                    cnt_nxt = cnt - 16'd1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mdio_arb.sv
// tb_mdio_arb - directed and randomized bench for mdio_arb (NREQ=3,
// TIMEOUT=16). The bench plays the driver itself and predicts grants,
// captured fields and completions from a behavioural model of the client
// slots and the round-robin rule.
module tb_mdio_arb;

    localparam int N  = 3;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_exec;
    logic [2:0]    req_rh_wl;
    logic [14:0]   req_addr;
    logic [47:0]   req_wr_data;
    logic [2:0]    req_busy;
    logic [2:0]    req_done;
    logic          req_err;
    logic [15:0]   req_rd_data;
    logic          req_rd_ack;
    logic          op_exec;
    logic          op_rh_wl;
    logic [4:0]    op_addr;
    logic [15:0]   op_wr_data;
    logic          op_done;
    logic [15:0]   op_rd_data;
    logic          op_rd_ack;

    mdio_arb #(.NREQ(N), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_exec    (req_exec),
        .req_rh_wl   (req_rh_wl),
        .req_addr    (req_addr),
        .req_wr_data (req_wr_data),
        .req_busy    (req_busy),
        .req_done    (req_done),
        .req_err     (req_err),
        .req_rd_data (req_rd_data),
        .req_rd_ack  (req_rd_ack),
        .op_exec     (op_exec),
        .op_rh_wl    (op_rh_wl),
        .op_addr     (op_addr),
        .op_wr_data  (op_wr_data),
        .op_done     (op_done),
        .op_rd_data  (op_rd_data),
        .op_rd_ack   (op_rd_ack)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: one slot per client, plus the index of the last grant.
    bit         m_pend [N];
    bit         m_rw   [N];
    logic [4:0] m_addr [N];
    logic [15:0] m_wd  [N];
    int         m_last;
    int         m_g;

    int          n;
    int          guard;
    logic [2:0]  mk;
    logic [15:0] rnd_rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] m_vec();
        logic [2:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic int model_pick();
        for (int k = 1; k <= N; k++) begin
            if (m_pend[(m_last + k) % N]) return (m_last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        m_last = N - 1;
        m_g    = 0;
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_op_exec"},  op_exec,     0);
        chk({tag, "_op_rh_wl"}, op_rh_wl,    0);
        chk({tag, "_op_addr"},  op_addr,     0);
        chk({tag, "_op_wd"},    op_wr_data,  0);
        chk({tag, "_busy"},     req_busy,    0);
        chk({tag, "_done"},     req_done,    0);
        chk({tag, "_err"},      req_err,     0);
        chk({tag, "_rd_data"},  req_rd_data, 0);
        chk({tag, "_rd_ack"},   req_rd_ack,  1);
    endtask

    // Drive one cycle of client start pulses; the model applies the
    // "accept only when not busy" rule against its own pending flags.
    task automatic drive_req(logic [2:0] mask, logic [2:0] rw,
                             logic [14:0] addr, logic [47:0] wd);
        req_exec    = mask;
        req_rh_wl   = rw;
        req_addr    = addr;
        req_wr_data = wd;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && !m_pend[i]) begin
                m_pend[i] = 1'b1;
                m_rw[i]   = rw[i];
                m_addr[i] = addr[5*i +: 5];
                m_wd[i]   = wd[16*i +: 16];
            end
        end
        tick();
        req_exec = '0;
        chk("busy_after_req", req_busy, m_vec());
    endtask

    task automatic wait_exec(output int cyc);
        cyc = 0;
        while (op_exec !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("exec_seen", op_exec, 1);
        m_g = model_pick();
        chk("grant_exists", (m_g >= 0), 1);
        if (m_g < 0) m_g = 0;
        chk("op_rh_wl", op_rh_wl, m_rw[m_g]);
        chk("op_addr", op_addr, m_addr[m_g]);
        chk("op_wr_data", op_wr_data, m_wd[m_g]);
        m_last = m_g;
    endtask

    task automatic complete(int lat, logic [15:0] rd, logic ack);
        logic [2:0] e;
        tick();
        chk("exec_one_cycle", op_exec, 0);
        for (int j = 1; j < lat; j++) tick();
        op_done    = 1'b1;
        op_rd_data = rd;
        op_rd_ack  = ack;
        tick();
        op_done = 1'b0;
        e = 3'b001 << m_g;
        m_pend[m_g] = 1'b0;
        chk("done_vec", req_done, e);
        chk("done_err", req_err, 0);
        chk("done_rd_data", req_rd_data, rd);
        chk("done_rd_ack", req_rd_ack, ack);
        chk("done_busy", req_busy, m_vec());
    endtask

    // already = cycles already spent since the op_exec cycle.
    task automatic expect_timeout(int already);
        logic [2:0] e;
        for (int j = already + 1; j <= TO + 1; j++) begin
            tick();
            if (j <= TO) chk("to_quiet", req_done, 0);
        end
        e = 3'b001 << m_g;
        m_pend[m_g] = 1'b0;
        chk("to_done_vec", req_done, e);
        chk("to_err", req_err, 1);
        chk("to_rd_data", req_rd_data, 0);
        chk("to_rd_ack", req_rd_ack, 1);
        chk("to_busy", req_busy, m_vec());
    endtask

    initial begin
        rst         = 1'b1;
        req_exec    = '0;
        req_rh_wl   = '0;
        req_addr    = '0;
        req_wr_data = '0;
        op_done     = 1'b0;
        op_rd_data  = '0;
        op_rd_ack   = 1'b1;
        model_reset();
        repeat (3) tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();

        // Round-robin: all three at once, then 0 and 1 again during 2's op.
        drive_req(3'b111, 3'b000, {5'h0C, 5'h0B, 5'h0A},
                  {16'hC2C2, 16'hB1B1, 16'hA0A0});
        wait_exec(n);
        chk("rr_latency", n, 1);
        chk("rr_first", op_addr, 5'h0A);
        complete(2, 16'h1111, 1'b0);
        wait_exec(n);
        chk("rr_second_lat", n, 1);
        chk("rr_second", op_addr, 5'h0B);
        complete(3, 16'h2222, 1'b1);
        wait_exec(n);
        chk("rr_third", op_addr, 5'h0C);
        drive_req(3'b011, 3'b011, {5'h00, 5'h1B, 5'h1A},
                  {16'h0, 16'h0B0B, 16'h0A0A});
        complete(2, 16'h3333, 1'b0);
        wait_exec(n);
        chk("rr_no_starve", op_addr, 5'h1A);
        complete(1, 16'h4444, 1'b0);
        wait_exec(n);
        chk("rr_then_1", op_addr, 5'h1B);
        complete(1, 16'h5555, 1'b0);

        // Single read from client 1.
        drive_req(3'b010, 3'b010, {5'h00, 5'h01, 5'h00}, 48'h0);
        wait_exec(n);
        chk("rd_latency", n, 1);
        chk("rd_addr", op_addr, 5'h01);
        chk("rd_dir", op_rh_wl, 1);
        complete(3, 16'h796D, 1'b0);
        chk("rd_done", req_done, 3'b010);
        chk("rd_data", req_rd_data, 16'h796D);

        // Drop while busy: second pulse from client 0 must be ignored.
        drive_req(3'b001, 3'b000, 15'h0, {32'h0, 16'h8000});
        wait_exec(n);
        chk("drop_wd", op_wr_data, 16'h8000);
        drive_req(3'b001, 3'b000, 15'h0, {32'h0, 16'h1234});
        complete(2, 16'hAAAA, 1'b1);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("drop_no_second_op", op_exec, 0);
        end

        // Timeout on client 0 with client 1 queued behind it.
        drive_req(3'b001, 3'b001, {10'h0, 5'h03}, 48'h0);
        wait_exec(n);
        drive_req(3'b010, 3'b000, {5'h00, 5'h04, 5'h00}, {16'h0, 16'h4242, 16'h0});
        expect_timeout(1);
        wait_exec(n);
        chk("to_next_lat", n, 1);
        chk("to_next_addr", op_addr, 5'h04);
        complete(2, 16'h0F0F, 1'b0);

        // Back-to-back re-issue from client 2 in its own done cycle.
        drive_req(3'b100, 3'b100, {5'h07, 10'h0}, 48'h0);
        wait_exec(n);
        complete(1, 16'h5A5A, 1'b0);
        chk("b2b_done", req_done, 3'b100);
        drive_req(3'b100, 3'b000, {5'h09, 10'h0}, {16'h9999, 32'h0});
        wait_exec(n);
        chk("b2b_latency", n, 1);
        chk("b2b_addr", op_addr, 5'h09);
        complete(2, 16'h6666, 1'b1);

        // Reset in the middle of WAIT, then a stale op_done.
        drive_req(3'b001, 3'b001, {10'h0, 5'h11}, 48'h0);
        wait_exec(n);
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        op_done    = 1'b1;
        op_rd_data = 16'hBEEF;
        op_rd_ack  = 1'b0;
        tick();
        op_done = 1'b0;
        chk_reset("post_rst");
        tick();
        chk("post_rst_no_done", req_done, 0);
        drive_req(3'b101, 3'b000, {5'h15, 5'h00, 5'h14}, {16'h5151, 16'h0, 16'h4141});
        wait_exec(n);
        chk("post_rst_first", op_addr, 5'h14);
        complete(2, 16'h0101, 1'b0);
        wait_exec(n);
        chk("post_rst_second", op_addr, 5'h15);
        complete(2, 16'h0202, 1'b0);

        // Randomized traffic against the model.
        for (int it = 0; it < 25; it++) begin
            mk = 3'($urandom_range(1, 7));
            drive_req(mk, 3'($urandom), 15'($urandom),
                      {16'($urandom), 16'($urandom), 16'($urandom)});
            guard = 0;
            while (m_vec() != 3'b000 && guard < 20) begin
                wait_exec(n);
                chk("rand_latency", n, 1);
                n = 0;
                if ($urandom_range(0, 2) == 0) begin
                    drive_req(3'($urandom), 3'($urandom), 15'($urandom),
                              {16'($urandom), 16'($urandom), 16'($urandom)});
                    n = 1;
                end
                if ($urandom_range(0, 7) == 0) begin
                    expect_timeout(n);
                end else begin
                    rnd_rd = 16'($urandom);
                    complete($urandom_range(1, 6), rnd_rd, 1'($urandom));
                end
                guard++;
            end
            chk("rand_drained", req_busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mdio_arb.md
# mdio_arb

MDIO access arbiter placed between up to NREQ independent register-access clients and the single MDIO driver (`mdio_dri`) op interface. It latches one pending request per client and grants them round-robin. It issues exactly one driver operation at a time and routes the completion, read data and acknowledge back to the granted client. A watchdog aborts any operation the driver never completes, so a stuck PHY cannot block the other clients.

## Interface
Parameters:
- NREQ, 3 — number of clients, legal range 2..8
- TIMEOUT, 1023 — cycles allowed from op_exec to op_done before abort, legal range 16..65535

Ports:
- clk  in  1  — driver clock domain (same clock as the driver's dri_clk); one clock
- rst  in  1  — reset is asynchronous and active-high
- req_exec  in  NREQ  — per-client start pulse
- req_rh_wl  in  NREQ  — per-client direction: 1 = read, 0 = write
- req_addr  in  5*NREQ  — client i register address at [5i+4:5i]
- req_wr_data  in  16*NREQ  — client i write data at [16i+15:16i]
- req_busy  out  NREQ  — client i has a request pending or in flight
- req_done  out  NREQ  — one-cycle completion pulse to client i
- req_err  out  1  — valid with req_done; 1 = aborted by timeout
- req_rd_data  out  16  — shared read data, valid with req_done
- req_rd_ack  out  1  — shared PHY ack, valid with req_done; 0 = PHY acknowledged
- op_exec  out  1  — start pulse to driver
- op_rh_wl  out  1  — to driver
- op_addr  out  5  — to driver
- op_wr_data  out  16  — to driver
- op_done  in  1  — driver completion pulse
- op_rd_data  in  16  — driver read data
- op_rd_ack  in  1  — driver ack flag, 0 = acknowledged

## Operation
- Request capture: when req_exec[i]=1 and req_busy[i]=0, latch rh_wl, addr and wr_data into slot i and set pending[i]. When req_exec[i]=1 and req_busy[i]=1, the pulse is dropped silently.
- req_busy = pending; the bit stays high through the grant and clears at the edge that raises req_done[i].
- FSM states:
  - IDLE: if any pending, select the first pending index searching from last_grant+1 modulo NREQ, load the op_* registers, pulse op_exec and go to WAIT.
  - WAIT: count cycles. On op_done, latch op_rd_data and op_rd_ack, pulse req_done[g] with req_err=0, clear pending[g] and go to IDLE. If the count reaches TIMEOUT first, pulse req_done[g] with req_err=1, req_rd_data=0, req_rd_ack=1, clear pending[g] and go to IDLE.
- last_grant updates on grant; its reset value is NREQ-1, so client 0 wins first.
- op_addr, op_rh_wl and op_wr_data hold the granted values until the next grant.
- op_done in IDLE is ignored. op_done in the same cycle as the timeout terminal count is treated as a normal completion.
- Write operations return req_rd_data equal to the driver's op_rd_data, unfiltered.

## Timing
- All outputs are registered. Reset values: op_exec=0, op_rh_wl=0, op_addr=0, op_wr_data=0, req_busy=0, req_done=0, req_err=0, req_rd_data=0, req_rd_ack=1. Reset also clears pending, the counter and the FSM (→ IDLE), and sets last_grant=NREQ-1.
- req_exec at edge t with the FSM idle → pending at t+1 → op_exec high for exactly cycle t+2.
- op_done at cycle d → req_done, req_rd_data, req_rd_ack and req_err valid in cycle d+1, with req_busy[g]=0 in that cycle → next op_exec no earlier than d+2.
- req_exec[g] asserted during its own req_done cycle is accepted, because busy is already 0.
- Timeout: req_done is raised TIMEOUT+1 cycles after op_exec.
- Reset asserted mid-operation: everything is abandoned. A late op_done from the driver arrives in IDLE and is ignored.

## Test plan
- Single read: client 1 issues read of addr 5'h01; driver model returns 16'h796D, ack 0 → op_exec at t+2 with op_addr=01, op_rh_wl=1; req_done=3'b010, req_rd_data=796D, req_rd_ack=0, req_err=0.
- Round-robin: all three clients pulse req_exec in the same cycle → grant order 0,1,2. Client 0 then requests again during client 2's operation → it is granted next, with no starvation.
- Drop while busy: client 0 write addr 00, data 16'h8000, then a second req_exec with data 1234 while busy → exactly one driver op, with op_wr_data=8000.
- Timeout: driver model never pulses op_done, TIMEOUT=16 → req_done[0] exactly 17 cycles after op_exec, req_err=1, req_rd_data=0, req_rd_ack=1; client 1's pending op then issues.
- Back-to-back re-issue: client 2 pulses req_exec in its req_done cycle → accepted; op_exec two cycles later.
- Reset mid-WAIT: assert rst during WAIT, then inject op_done after release → no req_done, all outputs at reset values, and a new request proceeds normally.
